// File: rtl/fp16_div_if.sv
// Operand/result handshake bundle for the fp16 divider.
interface fp16_div_if;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] q;
    logic        out_valid;
    logic        out_ready;
    logic        sNaN_o;
    logic        qNaN_o;
    logic        infinity_o;
    logic        zero_o;
    logic        subnormal_o;
    logic        normal_o;
    logic        dz_o;

    modport master (
        output op_a, op_b, in_valid, out_ready,
        input  in_ready, q, out_valid,
        input  sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, dz_o
    );

    modport slave (
        input  op_a, op_b, in_valid, out_ready,
        output in_ready, q, out_valid,
        output sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, dz_o
    );
endinterface

// File: rtl/fp16_div.sv
// Iterative binary16 divider: restoring division one quotient bit per clock,
// truncating result with one-hot class flags.
module fp16_div #(
    parameter int unsigned QBITS = 13
) (
    input  logic         clk,
    input  logic         rst,
    fp16_div_if.slave    bus
);
    localparam int unsigned SIG_W = 11;
    localparam int unsigned REM_W = 12;
    localparam int unsigned CNT_W = $clog2(QBITS);

    // class vector layout: {sNaN, qNaN, inf, zero, subnormal, normal}
    localparam logic [5:0] C_SNAN = 6'b100000;
    localparam logic [5:0] C_QNAN = 6'b010000;
    localparam logic [5:0] C_INF  = 6'b001000;
    localparam logic [5:0] C_ZERO = 6'b000100;
    localparam logic [5:0] C_SUB  = 6'b000010;
    localparam logic [5:0] C_NORM = 6'b000001;

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIV, S_PACK, S_DONE} state_t;

    state_t                r_state;
    logic [15:0]           r_a;
    logic [15:0]           r_b;
    logic                  r_sign;
    logic signed [7:0]     r_exp;
    logic [REM_W-1:0]      r_rem;
    logic [SIG_W-1:0]      r_sig_b;
    logic [QBITS-1:0]      r_quo;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_q;
    logic [5:0]            r_cls;
    logic                  r_dz;
    logic                  r_out_valid;

    // Returns {unbiased exponent[7:0], significand 1.xxx[10:0]}; subnormals are normalised.
    function automatic logic [18:0] norm_op(input logic [14:0] x);
        logic [3:0]  lz;
        logic        found;
        logic [7:0]  ex;
        logic [10:0] sig;
        lz    = 4'd0;
        found = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            if (!found && x[i]) begin
                lz    = 4'(9 - i);
                found = 1'b1;
            end
        end
        if (x[14:10] == 5'd0) begin
            ex  = 8'hF1 - {4'd0, lz};
            sig = 11'({1'b0, x[9:0]} << (lz + 4'd1));
        end else begin
            ex  = {3'd0, x[14:10]} - 8'd15;
            sig = {1'b1, x[9:0]};
        end
        return {ex, sig};
    endfunction

    logic [18:0]       w_na;
    logic [18:0]       w_nb;
    logic              w_sign;
    logic              w_spec;
    logic [15:0]       w_spec_q;
    logic [5:0]        w_spec_cls;
    logic              w_spec_dz;

    assign w_na   = norm_op(r_a[14:0]);
    assign w_nb   = norm_op(r_b[14:0]);
    assign w_sign = r_a[15] ^ r_b[15];

    // Special-operand resolution in priority order.
    always_comb begin
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        a_nan  = (&r_a[14:10]) && (|r_a[9:0]);
        b_nan  = (&r_b[14:10]) && (|r_b[9:0]);
        a_inf  = (&r_a[14:10]) && !(|r_a[9:0]);
        b_inf  = (&r_b[14:10]) && !(|r_b[9:0]);
        a_zero = !(|r_a[14:0]);
        b_zero = !(|r_b[14:0]);
        w_spec     = 1'b1;
        w_spec_q   = 16'd0;
        w_spec_cls = 6'd0;
        w_spec_dz  = 1'b0;
        if (a_nan && !r_a[9]) begin
            w_spec_q = r_a;  w_spec_cls = C_SNAN;
        end else if (b_nan && !r_b[9]) begin
            w_spec_q = r_b;  w_spec_cls = C_SNAN;
        end else if (a_nan) begin
            w_spec_q = r_a;  w_spec_cls = C_QNAN;
        end else if (b_nan) begin
            w_spec_q = r_b;  w_spec_cls = C_QNAN;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            w_spec_q = 16'h7E00;  w_spec_cls = C_QNAN;
        end else if (a_inf) begin
            w_spec_q = {w_sign, 15'h7C00};  w_spec_cls = C_INF;
        end else if (b_inf) begin
            w_spec_q = {w_sign, 15'd0};  w_spec_cls = C_ZERO;
        end else if (b_zero) begin
            w_spec_q = {w_sign, 15'h7C00};  w_spec_cls = C_INF;  w_spec_dz = 1'b1;
        end else if (a_zero) begin
            w_spec_q = {w_sign, 15'd0};  w_spec_cls = C_ZERO;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic              w_ge;
    logic [REM_W-1:0]  w_rem_next;

    assign w_ge       = r_rem >= {1'b0, r_sig_b};
    assign w_rem_next = w_ge ? REM_W'((r_rem - {1'b0, r_sig_b}) << 1) : REM_W'(r_rem << 1);

    logic signed [7:0] w_e;
    logic [SIG_W-1:0]  w_m;
    logic [3:0]        w_sh;
    logic [9:0]        w_subm;
    logic [15:0]       w_pack_q;
    logic [5:0]        w_pack_cls;

    // Normalise the quotient and range-classify the exponent.
    always_comb begin
        w_m        = r_quo[QBITS-1] ? r_quo[QBITS-1 -: SIG_W] : r_quo[QBITS-2 -: SIG_W];
        w_e        = r_quo[QBITS-1] ? r_exp : r_exp - 8'sd1;
        w_sh       = 4'(-8'sd14 - w_e);
        w_subm     = 10'(w_m >> w_sh);
        w_pack_q   = 16'd0;
        w_pack_cls = 6'd0;
        if (w_e > 8'sd15) begin
            w_pack_q = {r_sign, 15'h7C00};  w_pack_cls = C_INF;
        end else if (w_e < -8'sd24) begin
            w_pack_q = {r_sign, 15'd0};  w_pack_cls = C_ZERO;
        end else if (w_e < -8'sd14) begin
            if (w_subm == 10'd0) begin
                w_pack_q = {r_sign, 15'd0};  w_pack_cls = C_ZERO;
            end else begin
                w_pack_q = {r_sign, 5'd0, w_subm};  w_pack_cls = C_SUB;
            end
        end else begin
            w_pack_q = {r_sign, 5'(w_e + 8'sd15), w_m[9:0]};  w_pack_cls = C_NORM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q         <= 16'd0;
            r_cls       <= 6'd0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sign  <= w_sign;
                    r_exp   <= w_na[18:11] - w_nb[18:11];
                    r_rem   <= {1'b0, w_na[10:0]};
                    r_sig_b <= w_nb[10:0];
                    r_quo   <= '0;
                    r_cnt   <= CNT_W'(QBITS - 1);
                    if (w_spec) begin
                        r_q     <= w_spec_q;
                        r_cls   <= w_spec_cls;
                        r_dz    <= w_spec_dz;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[QBITS-2:0], w_ge};
                    if (r_cnt == '0) r_state <= S_PACK;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                S_PACK: begin
                    r_q     <= w_pack_q;
                    r_cls   <= w_pack_cls;
                    r_dz    <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // Result registers settle one cycle before out_valid is raised.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE) && !rst;
    assign bus.q           = r_q;
    assign bus.out_valid   = r_out_valid;
    assign bus.sNaN_o      = r_cls[5];
    assign bus.qNaN_o      = r_cls[4];
    assign bus.infinity_o  = r_cls[3];
    assign bus.zero_o      = r_cls[2];
    assign bus.subnormal_o = r_cls[1];
    assign bus.normal_o    = r_cls[0];
    assign bus.dz_o        = r_dz;

endmodule
